// File: rtl/seq_checker_pkg.sv
// seq_checker_pkg: shared state encoding and default parameters for the sequence checker
package seq_checker_pkg;
    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_LOCK_THR = 8;
    localparam int DEF_LOSS_THR = 4;
    localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/seq_checker_sat_cnt.sv
// sat_cnt: saturating up-counter; clear and increment in the same cycle yield 1
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (clr) cnt <= inc ? W'(1) : '0;
        else if (inc && cnt != '1) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/seq_checker.sv
// seq_checker: lock/loss tracking and error statistics for an incrementing-counter stream
module seq_checker
    import seq_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LOCK_THR = DEF_LOCK_THR,
    parameter int LOSS_THR = DEF_LOSS_THR,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [31:0]      word_cnt
);
    localparam int MC_W = $clog2(LOCK_THR + 1);
    localparam int MS_W = $clog2(LOSS_THR + 1);
    state_t state;
    logic [WIDTH-1:0] ref_q, exp_word;
    logic [MC_W-1:0] match_cnt;
    logic [MS_W-1:0] miss_cnt;
    logic match, hit, miss;
    always_comb begin
        exp_word = ref_q + 1'b1;
        match = in_data == exp_word;
        hit = in_valid && state == LOCKED;
        miss = hit && !match;
    end
    // In LOCKED the reference free-runs so one corrupted word costs exactly one error
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
            ref_q <= '0;
            match_cnt <= '0;
            miss_cnt <= '0;
            locked <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= miss;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        ref_q <= in_data;
                        match_cnt <= '0;
                        state <= SYNC;
                    end
                    SYNC: begin
                        ref_q <= in_data;
                        match_cnt <= match ? match_cnt + 1'b1 : '0;
                        if (match && int'(match_cnt) == LOCK_THR - 1) begin
                            state <= LOCKED;
                            locked <= 1'b1;
                            miss_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        ref_q <= exp_word;
                        miss_cnt <= match ? '0 : miss_cnt + 1'b1;
                        if (!match && int'(miss_cnt) == LOSS_THR - 1) begin
                            state <= HUNT;
                            locked <= 1'b0;
                            miss_cnt <= '0;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
    sat_cnt #(.W(CNT_W)) u_err_cnt (.clk(clk), .rst(rst), .inc(miss), .clr(clear), .cnt(err_cnt));
    sat_cnt #(.W(32)) u_word_cnt (.clk(clk), .rst(rst), .inc(hit), .clr(clear), .cnt(word_cnt));
endmodule

// File: doc/seq_checker.md
SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 Parameter WIDTH, default 4: width of the received sequence word.
REQ-002 Parameter LOCK_THR, default 8: consecutive matching words required to declare lock.
REQ-003 Parameter LOSS_THR, default 4: consecutive mismatching words in lock that force loss of lock.
REQ-004 Parameter CNT_W, default 16: width of the error counter.
REQ-005 Port clk, input, 1: the single clock; all logic SHALL be synchronous to its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port in_data, input, WIDTH: received word from the free-running incrementing-counter source.
REQ-008 Port in_valid, input, 1: in_data is sampled only when high.
REQ-009 Port clear, input, 1: synchronous clear of the statistics counters.
REQ-010 Port locked, output, 1: high while the checker is in state LOCKED.
REQ-011 Port err_pulse, output, 1: one-cycle strobe per mismatching word received while locked.
REQ-012 Port err_cnt, output, CNT_W: saturating count of mismatching words received while locked.
REQ-013 Port word_cnt, output, 32: saturating count of valid words received while locked.

Function
REQ-014 Expected word SHALL be ref+1 modulo 2**WIDTH; wrap-around from all-ones to zero SHALL count as a match.
REQ-015 States SHALL be HUNT, SYNC and LOCKED; cycles with in_valid low SHALL change no state, reference or counter.
REQ-016 HUNT: first valid word -> ref<=in_data, match_cnt<=0, go to SYNC.
REQ-017 SYNC: match -> match_cnt+1 and ref<=in_data; mismatch -> match_cnt<=0 and ref<=in_data (re-seed), stay in SYNC.
REQ-018 SYNC -> LOCKED on the valid word that makes match_cnt equal LOCK_THR; locked SHALL rise on the following cycle.
REQ-019 LOCKED: ref<=expected on every valid word regardless of match, so a single corrupted word costs exactly one error.
REQ-020 LOCKED mismatch -> err_pulse high for exactly one cycle, on the cycle after the offending valid; err_cnt+1; miss_cnt+1.
REQ-021 LOCKED match -> miss_cnt<=0; word_cnt SHALL increment on every valid word in LOCKED, matching or not.
REQ-022 When miss_cnt reaches LOSS_THR, the FSM SHALL go to HUNT, and locked SHALL fall on the following cycle.
REQ-023 err_cnt and word_cnt SHALL saturate at their all-ones value and never wrap.
REQ-024 clear SHALL zero err_cnt and word_cnt without affecting FSM state, ref, match_cnt or miss_cnt.
REQ-025 clear coincident with a counted event: the counter SHALL take the value 1 (clear applied, event counted).
REQ-026 All outputs SHALL be registered; latency from an in_valid sample to the output response is 1 cycle.

Reset
REQ-027 rst SHALL put the FSM in HUNT and zero ref, match_cnt, miss_cnt, locked, err_pulse, err_cnt and word_cnt on the next edge.
REQ-028 rst asserted mid-lock SHALL override all other inputs, including in_valid and clear.

Structure
REQ-029 Package seq_checker_pkg SHALL hold the state enum (HUNT, SYNC, LOCKED) and the default parameter constants.
REQ-030 Saturating counters SHALL be implemented by one sub-module, sat_cnt (parameterised width, with inc and clr inputs), instantiated twice.

Verification
(All scenarios use WIDTH=4, LOCK_THR=8, LOSS_THR=4.)
REQ-031 Continuous counter 0..15..0 with in_valid held high, after reset -> locked rises 1 cycle after the 9th word; wrap 15->0 produces no error; err_cnt stays 0.
REQ-032 Locked stream with one word 5 replaced by 9 -> exactly one err_pulse; err_cnt=1; locked stays high; the next word 6 matches.
REQ-033 Locked stream with a permanent slip (value 7 skipped) -> 4 err_pulses; locked falls; relocks 1 cycle after 9 further valid words; err_cnt=4.
REQ-034 Locked stream with random in_valid gaps while in_data holds or changes during invalid cycles -> no errors; word_cnt equals the number of valid words.
REQ-035 Same bench with CNT_W=4 and alternating good/bad words for 40 words -> locked stays high; err_cnt saturates at 15; clear then asserted together with an error -> err_cnt=1.
REQ-036 rst asserted while locked with err_cnt=3 -> next cycle locked=0, err_cnt=0, word_cnt=0, err_pulse=0; FSM in HUNT.
